ahb_master_arbiter: RTL and testbench
=====================================

// Module: ahb_master_arbiter
// PURPOSE
//  Shares one AHB-Lite bus between two AHB-Lite masters: M0 is the PicoRV32 and M1 is a DMA/debug master.
//  The output bus feeds ahb_interconnect and the slaves unchanged.
//  Each master has an input stage that captures its address phase when the bus is not available to it.
//  Arbitration runs per transfer, round-robin or fixed priority; a non-granted master is stalled through its HREADY.
// PARAMETERS
//  ROUND_ROBIN  1  1: alternate grant on contention; 0: fixed priority
//  PRIO_MASTER  0  winner on contention when ROUND_ROBIN=0; initial RR pointer value
// PORTS
//  HCLK          in   1   system clock
//  HRESETn       in   1   asynchronous active-low reset
//  Mx_HADDR      in   32  master x address (x=0,1)
//  Mx_HTRANS     in   2   master x transfer type
//  Mx_HWRITE     in   1   master x write
//  Mx_HSIZE      in   3   master x size
//  Mx_HWDATA     in   32  master x write data
//  Mx_HRDATA     out  32  read data to master x (= HRDATA)
//  Mx_HREADY     out  1   ready to master x
//  Mx_HRESP      out  1   response to master x
//  HADDR         out  32  shared bus address
//  HTRANS        out  2   shared bus transfer type (IDLE or NONSEQ only)
//  HWRITE        out  1   shared bus write
//  HSIZE         out  3   shared bus size
//  HWDATA        out  32  shared bus write data
//  HRDATA        in   32  shared bus read data
//  HREADY        in   1   shared bus ready (from interconnect)
//  HRESP         in   1   shared bus response
// BEHAVIOUR
//  - Request from master x: Mx_HTRANS[1]=1 while Mx_HREADY=1. SEQ is issued as NONSEQ; BUSY is treated as IDLE.
//  - Per-master state: pend_x plus a holding register {addr, write, size}.
//    - Source of request x = holding register if pend_x=1, else the live Mx signals.
//  - Grant: evaluated every cycle with HREADY=1 over the active requests (pend_x, or a live request).
//    - Only one requester: it wins.
//    - Both request, ROUND_ROBIN=1: the master not granted last wins. rr_last updates on every issued transfer.
//    - Both request, ROUND_ROBIN=0: PRIO_MASTER wins.
//  - Address phase:
//    - Winner's source drives HADDR/HWRITE/HSIZE with HTRANS=NONSEQ.
//    - No requester: HTRANS=IDLE; HADDR/HWRITE/HSIZE hold their last values.
//  - Capture: a live request that is not issued this cycle (it lost, or HREADY=0) sets pend_x and loads the holding register.
//    - pend_x clears on the cycle its request is issued with HREADY=1.
//  - Data owner register: d_own in {NONE, M0, M1}. On HREADY=1 it loads the issued master, or NONE if HTRANS=IDLE.
//    - HWDATA = Mx_HWDATA of d_own; 0 when d_own=NONE.
//  - Mx_HREADY:
//    - d_own=x: equals HREADY.
//    - Else pend_x=1, or request x issued and awaiting its data phase: 0.
//    - Otherwise 1.
//  - Mx_HRESP = HRESP when d_own=x, else 0. The two-cycle ERROR response passes straight through.
//    - A pending request of the other master is unaffected by the error; the erroring master may drop its next request.
//  - Latency:
//    - An uncontended live request with HREADY=1 is issued in the same cycle, adding no wait states.
//    - A contended or stalled request is issued on the first HREADY=1 cycle in which it wins. With ROUND_ROBIN=1 that is at most one transfer later.
//  - Boundaries:
//    - HREADY=0 freezes grant, holding registers and the address phase; the bus address stays stable.
//    - A master never has more than one outstanding request, because its HREADY stays low until its data phase completes.
//  - Reset (asynchronous, including mid-transfer): pend_x=0, d_own=NONE, rr_last=~PRIO_MASTER.
//    - Outputs under reset: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, Mx_HREADY=1, Mx_HRESP=0.
// TESTING
//  1. M0 NONSEQ read of 0x0000_0010 with M1 IDLE and no wait states:
//     -> HADDR=0x10 and HTRANS=2 in the same cycle; M0_HREADY=1 in the next cycle; M0_HRDATA matches the slave data.
//  2. After reset, both masters issue NONSEQ in the same cycle (M0 to 0x10, M1 to 0x2000_0000):
//     -> M0 is issued in cycle N and M1 in cycle N+1 from its holding register.
//     -> M1_HREADY=0 until its data phase completes in N+2.
//  3. Both masters stream back-to-back with ROUND_ROBIN=1: grants alternate 0,1,0,1.
//     With ROUND_ROBIN=0 and PRIO_MASTER=0: M1 is issued only in gaps of M0.
//  4. Slave holds HREADY=0 for 3 cycles while M1 is pending:
//     -> HADDR is stable throughout; exactly one transfer per master reaches the bus.
//  5. Slave returns ERROR to M0 while M1 is pending:
//     -> M0_HRESP is high for 2 cycles with M0_HREADY low then high; M1_HRESP stays 0; M1 completes normally.
//  6. Assert HRESETn=0 while M1 is pending and a bus data phase is in flight:
//     -> HTRANS=IDLE and Mx_HREADY=1 immediately; no stale transfer is issued after reset releases.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: shares one bus between M0 (CPU) and M1 (DMA/debug).
// Each master has a one-deep holding stage that captures a request the bus could not take.
// Arbitration is per transfer (round-robin or fixed priority). A master that does not
// own the bus is stalled through its own HREADY.
module ahb_master_arbiter #(
   parameter bit ROUND_ROBIN = 1'b1,
   parameter bit PRIO_MASTER = 1'b0
) (
   input  logic        i_hclk,
   input  logic        i_hresetn,
   // master 0
   input  logic [31:0] i_m0_haddr,
   input  logic [1:0]  i_m0_htrans,
   input  logic        i_m0_hwrite,
   input  logic [2:0]  i_m0_hsize,
   input  logic [31:0] i_m0_hwdata,
   output logic [31:0] o_m0_hrdata,
   output logic        o_m0_hready,
   output logic        o_m0_hresp,
   // master 1
   input  logic [31:0] i_m1_haddr,
   input  logic [1:0]  i_m1_htrans,
   input  logic        i_m1_hwrite,
   input  logic [2:0]  i_m1_hsize,
   input  logic [31:0] i_m1_hwdata,
   output logic [31:0] o_m1_hrdata,
   output logic        o_m1_hready,
   output logic        o_m1_hresp,
   // shared bus
   output logic [31:0] o_haddr,
   output logic [1:0]  o_htrans,
   output logic        o_hwrite,
   output logic [2:0]  o_hsize,
   output logic [31:0] o_hwdata,
   input  logic [31:0] i_hrdata,
   input  logic        i_hready,
   input  logic        i_hresp
);

   typedef enum logic [1:0] {
      OwnNone = 2'd0,
      OwnM0   = 2'd1,
      OwnM1   = 2'd2
   } own_e;

   localparam logic [1:0] HtransIdle   = 2'b00;
   localparam logic [1:0] HtransNonseq = 2'b10;

   // per-master holding stage
   logic        r_pend0, r_pend1;
   logic [31:0] r_hold0_addr, r_hold1_addr;
   logic        r_hold0_write, r_hold1_write;
   logic [2:0]  r_hold0_size, r_hold1_size;

   // arbitration and bus state
   own_e        r_d_own;
   logic        r_rr_last;
   logic [31:0] r_haddr;
   logic        r_hwrite;
   logic [2:0]  r_hsize;

   logic        w_m0_hready, w_m1_hready;
   logic        w_live0, w_live1;
   logic        w_req0, w_req1;
   logic        w_sel1;
   logic        w_issue, w_iss0, w_iss1;
   logic [31:0] w_src0_addr, w_src1_addr;
   logic        w_src0_write, w_src1_write;
   logic [2:0]  w_src0_size, w_src1_size;
   logic [31:0] w_bus_addr;
   logic        w_bus_write;
   logic [2:0]  w_bus_size;

   // SEQ/NONSEQ are distinguished only by HTRANS[0], which is not needed here
   logic w_unused_htrans;
   assign w_unused_htrans = ^{i_m0_htrans[0], i_m1_htrans[0]};

   // master-side ready: the data-phase owner follows the bus, a captured request waits
   always_comb begin
      w_m0_hready = (r_d_own == OwnM0) ? i_hready : ~r_pend0;
      w_m1_hready = (r_d_own == OwnM1) ? i_hready : ~r_pend1;
   end

   // request sources and winner selection
   always_comb begin
      // reset gating keeps the bus IDLE while HRESETn is low, even with masters requesting
      w_live0      = i_hresetn & i_m0_htrans[1] & w_m0_hready;
      w_live1      = i_hresetn & i_m1_htrans[1] & w_m1_hready;
      w_req0       = r_pend0 | w_live0;
      w_req1       = r_pend1 | w_live1;
      w_src0_addr  = r_pend0 ? r_hold0_addr  : i_m0_haddr;
      w_src0_write = r_pend0 ? r_hold0_write : i_m0_hwrite;
      w_src0_size  = r_pend0 ? r_hold0_size  : i_m0_hsize;
      w_src1_addr  = r_pend1 ? r_hold1_addr  : i_m1_haddr;
      w_src1_write = r_pend1 ? r_hold1_write : i_m1_hwrite;
      w_src1_size  = r_pend1 ? r_hold1_size  : i_m1_hsize;
      if (w_req0 && w_req1) begin
         w_sel1 = ROUND_ROBIN ? ~r_rr_last : PRIO_MASTER;
      end else begin
         w_sel1 = w_req1;
      end
      // transfers are only issued on HREADY=1, so wait states show IDLE with a frozen address
      w_issue = i_hready & (w_req0 | w_req1);
      w_iss0  = w_issue & ~w_sel1;
      w_iss1  = w_issue & w_sel1;
   end

   // shared bus address phase and write data mux
   always_comb begin
      w_bus_addr  = w_sel1 ? w_src1_addr  : w_src0_addr;
      w_bus_write = w_sel1 ? w_src1_write : w_src0_write;
      w_bus_size  = w_sel1 ? w_src1_size  : w_src0_size;
      o_htrans    = w_issue ? HtransNonseq : HtransIdle;
      o_haddr     = w_issue ? w_bus_addr  : r_haddr;
      o_hwrite    = w_issue ? w_bus_write : r_hwrite;
      o_hsize     = w_issue ? w_bus_size  : r_hsize;
      unique case (r_d_own)
         OwnM0:   o_hwdata = i_m0_hwdata;
         OwnM1:   o_hwdata = i_m1_hwdata;
         default: o_hwdata = 32'h0;
      endcase
   end

   // response routing back to the masters
   always_comb begin
      o_m0_hrdata = i_hrdata;
      o_m1_hrdata = i_hrdata;
      o_m0_hready = w_m0_hready;
      o_m1_hready = w_m1_hready;
      o_m0_hresp  = (r_d_own == OwnM0) & i_hresp;
      o_m1_hresp  = (r_d_own == OwnM1) & i_hresp;
   end

   // last driven address phase, round-robin history and data-phase owner
   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         r_haddr   <= 32'h0;
         r_hwrite  <= 1'b0;
         r_hsize   <= 3'b000;
         r_rr_last <= ~PRIO_MASTER;
         r_d_own   <= OwnNone;
      end else begin
         if (w_issue) begin
            r_haddr   <= w_bus_addr;
            r_hwrite  <= w_bus_write;
            r_hsize   <= w_bus_size;
            r_rr_last <= w_sel1;
         end
         if (i_hready) begin
            r_d_own <= w_iss0 ? OwnM0 : (w_iss1 ? OwnM1 : OwnNone);
         end
      end
   end

   // master 0 holding stage: capture a live request the bus did not take
   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         r_pend0       <= 1'b0;
         r_hold0_addr  <= 32'h0;
         r_hold0_write <= 1'b0;
         r_hold0_size  <= 3'b000;
      end else if (w_iss0) begin
         r_pend0 <= 1'b0;
      end else if (w_live0) begin
         r_pend0       <= 1'b1;
         r_hold0_addr  <= i_m0_haddr;
         r_hold0_write <= i_m0_hwrite;
         r_hold0_size  <= i_m0_hsize;
      end
   end

   // master 1 holding stage: capture a live request the bus did not take
   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         r_pend1       <= 1'b0;
         r_hold1_addr  <= 32'h0;
         r_hold1_write <= 1'b0;
         r_hold1_size  <= 3'b000;
      end else if (w_iss1) begin
         r_pend1 <= 1'b0;
      end else if (w_live1) begin
         r_pend1       <= 1'b1;
         r_hold1_addr  <= i_m1_haddr;
         r_hold1_write <= i_m1_hwrite;
         r_hold1_size  <= i_m1_hsize;
      end
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: a round-robin instance plus a fixed-priority
// instance sharing the same stimulus.
module tb_ahb_master_arbiter;

   logic        clk = 1'b0;
   logic        hresetn = 1'b0;
   logic [31:0] m0_haddr = '0, m1_haddr = '0;
   logic [1:0]  m0_htrans = '0, m1_htrans = '0;
   logic        m0_hwrite = 1'b0, m1_hwrite = 1'b0;
   logic [2:0]  m0_hsize = '0, m1_hsize = '0;
   logic [31:0] m0_hwdata = '0, m1_hwdata = '0;
   logic [31:0] hrdata = '0;
   logic        hready = 1'b1;
   logic        hresp = 1'b0;

   logic [31:0] m0_hrdata, m1_hrdata, haddr, hwdata;
   logic        m0_hready, m1_hready, m0_hresp, m1_hresp, hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;

   logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_haddr, fp_hwdata;
   logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp, fp_hwrite;
   logic [1:0]  fp_htrans;
   logic [2:0]  fp_hsize;

   int n_assert = 0;
   int n_fail = 0;
   int n_xfer = 0;
   logic cnt_en = 1'b0;

   always #5 clk = ~clk;

   ahb_master_arbiter #(.ROUND_ROBIN(1'b1), .PRIO_MASTER(1'b0)) dut (
      .i_hclk(clk), .i_hresetn(hresetn),
      .i_m0_haddr(m0_haddr), .i_m0_htrans(m0_htrans), .i_m0_hwrite(m0_hwrite),
      .i_m0_hsize(m0_hsize), .i_m0_hwdata(m0_hwdata), .o_m0_hrdata(m0_hrdata),
      .o_m0_hready(m0_hready), .o_m0_hresp(m0_hresp),
      .i_m1_haddr(m1_haddr), .i_m1_htrans(m1_htrans), .i_m1_hwrite(m1_hwrite),
      .i_m1_hsize(m1_hsize), .i_m1_hwdata(m1_hwdata), .o_m1_hrdata(m1_hrdata),
      .o_m1_hready(m1_hready), .o_m1_hresp(m1_hresp),
      .o_haddr(haddr), .o_htrans(htrans), .o_hwrite(hwrite), .o_hsize(hsize),
      .o_hwdata(hwdata), .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
   );

   ahb_master_arbiter #(.ROUND_ROBIN(1'b0), .PRIO_MASTER(1'b0)) dut_fp (
      .i_hclk(clk), .i_hresetn(hresetn),
      .i_m0_haddr(m0_haddr), .i_m0_htrans(m0_htrans), .i_m0_hwrite(m0_hwrite),
      .i_m0_hsize(m0_hsize), .i_m0_hwdata(m0_hwdata), .o_m0_hrdata(fp_m0_hrdata),
      .o_m0_hready(fp_m0_hready), .o_m0_hresp(fp_m0_hresp),
      .i_m1_haddr(m1_haddr), .i_m1_htrans(m1_htrans), .i_m1_hwrite(m1_hwrite),
      .i_m1_hsize(m1_hsize), .i_m1_hwdata(m1_hwdata), .o_m1_hrdata(fp_m1_hrdata),
      .o_m1_hready(fp_m1_hready), .o_m1_hresp(fp_m1_hresp),
      .o_haddr(fp_haddr), .o_htrans(fp_htrans), .o_hwrite(fp_hwrite), .o_hsize(fp_hsize),
      .o_hwdata(fp_hwdata), .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
   );

   // counts transfers accepted by the slave while enabled
   always @(posedge clk) begin
      if (cnt_en && hready && htrans == 2'b10) n_xfer <= n_xfer + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_masters();
      m0_htrans = 2'b00;
      m1_htrans = 2'b00;
   endtask

   task automatic do_reset();
      tick();
      hresetn = 1'b0;
      idle_masters();
      hready = 1'b1;
      hresp = 1'b0;
      tick();
      hresetn = 1'b1;
   endtask

   initial begin
      // reset state, with M0 already requesting
      m0_htrans = 2'b10;
      m0_haddr = 32'h0000_0044;
      #2;
      chk("rst_htrans", 32'(htrans), 32'd0);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hwrite", 32'(hwrite), 32'd0);
      chk("rst_hsize", 32'(hsize), 32'd0);
      chk("rst_m0_hready", 32'(m0_hready), 32'd1);
      chk("rst_m1_hready", 32'(m1_hready), 32'd1);
      chk("rst_m0_hresp", 32'(m0_hresp), 32'd0);
      do_reset();

      // 1: uncontended M0 read issues in the same cycle
      tick();
      m0_htrans = 2'b10; m0_haddr = 32'h0000_0010; m0_hwrite = 1'b0; m0_hsize = 3'd2;
      #2;
      chk("t1_htrans", 32'(htrans), 32'd2);
      chk("t1_haddr", haddr, 32'h10);
      chk("t1_m0_hready_a", 32'(m0_hready), 32'd1);
      tick();
      m0_htrans = 2'b00; hrdata = 32'hCAFE_0010;
      #2;
      chk("t1_m0_hready_d", 32'(m0_hready), 32'd1);
      chk("t1_m0_hrdata", m0_hrdata, 32'hCAFE_0010);
      chk("t1_htrans_idle", 32'(htrans), 32'd0);
      chk("t1_haddr_hold", haddr, 32'h10);

      // 2: simultaneous requests after reset
      do_reset();
      tick();
      m0_htrans = 2'b10; m0_haddr = 32'h0000_0010; m0_hwrite = 1'b1;
      m1_htrans = 2'b10; m1_haddr = 32'h2000_0000; m1_hwrite = 1'b0;
      #2;
      chk("t2_n_haddr", haddr, 32'h10);
      chk("t2_n_hwrite", 32'(hwrite), 32'd1);
      chk("t2_n_m1_hready", 32'(m1_hready), 32'd1);
      tick();
      idle_masters(); m0_hwdata = 32'hAAAA_0000; m1_hwdata = 32'h1111_1111;
      #2;
      chk("t2_n1_htrans", 32'(htrans), 32'd2);
      chk("t2_n1_haddr", haddr, 32'h2000_0000);
      chk("t2_n1_hwrite", 32'(hwrite), 32'd0);
      chk("t2_n1_hwdata", hwdata, 32'hAAAA_0000);
      chk("t2_n1_m1_hready", 32'(m1_hready), 32'd0);
      chk("t2_n1_m0_hready", 32'(m0_hready), 32'd1);
      tick();
      hrdata = 32'h5555_1234;
      #2;
      chk("t2_n2_m1_hready", 32'(m1_hready), 32'd1);
      chk("t2_n2_m1_hrdata", m1_hrdata, 32'h5555_1234);
      chk("t2_n2_hwdata", hwdata, 32'h1111_1111);
      chk("t2_n2_htrans", 32'(htrans), 32'd0);

      // 3: back-to-back streams, round-robin alternates, fixed priority starves M1
      do_reset();
      m0_haddr = 32'h100; m1_haddr = 32'h200;
      tick();
      m0_htrans = 2'b10; m1_htrans = 2'b10;
      #2;
      chk("t3_rr_c0", haddr, 32'h100);
      chk("t3_fp_c0", fp_haddr, 32'h100);
      tick(); #2;
      chk("t3_rr_c1", haddr, 32'h200);
      chk("t3_fp_c1", fp_haddr, 32'h100);
      chk("t3_fp_c1_m1_hready", 32'(fp_m1_hready), 32'd0);
      tick(); #2;
      chk("t3_rr_c2", haddr, 32'h100);
      chk("t3_fp_c2", fp_haddr, 32'h100);
      tick(); #2;
      chk("t3_rr_c3", haddr, 32'h200);
      chk("t3_fp_c3_m1_hready", 32'(fp_m1_hready), 32'd0);
      tick();
      m0_htrans = 2'b00;
      #2;
      chk("t3_fp_gap_htrans", 32'(fp_htrans), 32'd2);
      chk("t3_fp_gap_haddr", fp_haddr, 32'h200);

      // 4: three wait states while M1 is pending
      do_reset();
      tick();
      cnt_en = 1'b1;
      m0_htrans = 2'b10; m0_haddr = 32'h300; m0_hwrite = 1'b0;
      m1_htrans = 2'b10; m1_haddr = 32'h400;
      #2;
      chk("t4_c0_haddr", haddr, 32'h300);
      tick();
      idle_masters(); hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("t4_ws_haddr", haddr, 32'h300);
         chk("t4_ws_htrans", 32'(htrans), 32'd0);
         chk("t4_ws_m1_hready", 32'(m1_hready), 32'd0);
         chk("t4_ws_m0_hready", 32'(m0_hready), 32'd0);
         tick();
      end
      hready = 1'b1; hrdata = 32'h0BAD_F00D;
      #2;
      chk("t4_rel_htrans", 32'(htrans), 32'd2);
      chk("t4_rel_haddr", haddr, 32'h400);
      chk("t4_rel_m0_hready", 32'(m0_hready), 32'd1);
      chk("t4_rel_m0_hrdata", m0_hrdata, 32'h0BAD_F00D);
      tick(); #2;
      chk("t4_m1_data_hready", 32'(m1_hready), 32'd1);
      chk("t4_m1_data_htrans", 32'(htrans), 32'd0);
      tick(); #2;
      chk("t4_after_htrans", 32'(htrans), 32'd0);
      cnt_en = 1'b0;
      chk("t4_xfers", 32'(n_xfer), 32'd2);

      // 5: two-cycle ERROR to M0 with M1 pending
      do_reset();
      tick();
      m0_htrans = 2'b10; m0_haddr = 32'h500;
      m1_htrans = 2'b10; m1_haddr = 32'h600;
      #2;
      chk("t5_c0_haddr", haddr, 32'h500);
      tick();
      idle_masters(); hready = 1'b0; hresp = 1'b1;
      #2;
      chk("t5_e1_m0_hresp", 32'(m0_hresp), 32'd1);
      chk("t5_e1_m0_hready", 32'(m0_hready), 32'd0);
      chk("t5_e1_m1_hresp", 32'(m1_hresp), 32'd0);
      chk("t5_e1_htrans", 32'(htrans), 32'd0);
      tick();
      hready = 1'b1;
      #2;
      chk("t5_e2_m0_hresp", 32'(m0_hresp), 32'd1);
      chk("t5_e2_m0_hready", 32'(m0_hready), 32'd1);
      chk("t5_e2_m1_hresp", 32'(m1_hresp), 32'd0);
      chk("t5_e2_htrans", 32'(htrans), 32'd2);
      chk("t5_e2_haddr", haddr, 32'h600);
      tick();
      hresp = 1'b0; hrdata = 32'h600D_600D;
      #2;
      chk("t5_m1_hready", 32'(m1_hready), 32'd1);
      chk("t5_m1_hresp", 32'(m1_hresp), 32'd0);
      chk("t5_m1_hrdata", m1_hrdata, 32'h600D_600D);
      chk("t5_m0_hresp_end", 32'(m0_hresp), 32'd0);

      // 6: reset while M1 is pending and a data phase is stalled
      do_reset();
      tick();
      m0_htrans = 2'b10; m0_haddr = 32'h700;
      m1_htrans = 2'b10; m1_haddr = 32'h800;
      #2;
      chk("t6_c0_haddr", haddr, 32'h700);
      tick();
      idle_masters(); hready = 1'b0;
      #2;
      chk("t6_pend_m1_hready", 32'(m1_hready), 32'd0);
      hresetn = 1'b0;
      #1;
      chk("t6_rst_htrans", 32'(htrans), 32'd0);
      chk("t6_rst_m0_hready", 32'(m0_hready), 32'd1);
      chk("t6_rst_m1_hready", 32'(m1_hready), 32'd1);
      chk("t6_rst_haddr", haddr, 32'h0);
      hready = 1'b1;
      tick();
      tick();
      hresetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(); #2;
         chk("t6_post_htrans", 32'(htrans), 32'd0);
         chk("t6_post_m1_hready", 32'(m1_hready), 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
